// File: rtl/hog_axil_pkg.sv
// hog_axil_pkg: shared register map, response codes, FSM state types and
// helpers for the HOG accelerator AXI4-Lite control slave.
package hog_axil_pkg;

  // Word indices (byte address bits [4:2])
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_CFG0    = 3'd2;
  localparam logic [2:0] REG_CFG1    = 3'd3;
  localparam logic [2:0] REG_CFG2    = 3'd4;
  localparam logic [2:0] REG_CFG3    = 3'd5;
  localparam logic [2:0] REG_IRQ_EN  = 3'd6;
  localparam logic [2:0] REG_VERSION = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] HOG_VERSION = 32'h0001_0000;

  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_DONE_BIT  = 1;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  // Byte-lane merge of a new write word into the stored word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hog_axil_reg_bank.sv
// hog_axil_reg_bank: register decode, byte-enable merge, storage and read mux.
// Optional feature macro: HOG_AXIL_IRQ_EN (implements IRQ_EN and irq_o).
module hog_axil_reg_bank
  import hog_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata,
  output logic        wr_err,
  input  logic        ready_i,
  input  logic        done_i,
  output logic        start_o,
  output logic [31:0] cfg0_o,
  output logic [31:0] cfg1_o,
  output logic [31:0] cfg2_o,
  output logic [31:0] cfg3_o,
  output logic        irq_o
);

  logic irq_en_r;
  logic done_r;
  logic done_w1c;

  assign wr_err   = (waddr == REG_VERSION);
  assign done_w1c = we && (waddr == REG_STATUS) && wstrb[0] && wdata[STATUS_DONE_BIT];

  // Register storage, start pulse, sticky DONE and interrupt generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg0_o   <= 32'h0;
      cfg1_o   <= 32'h0;
      cfg2_o   <= 32'h0;
      cfg3_o   <= 32'h0;
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
      start_o  <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      start_o <= we && (waddr == REG_CTRL) && wstrb[0] && wdata[0];
      if (we) begin
        case (waddr)
          REG_CFG0: cfg0_o <= strb_merge(cfg0_o, wdata, wstrb);
          REG_CFG1: cfg1_o <= strb_merge(cfg1_o, wdata, wstrb);
          REG_CFG2: cfg2_o <= strb_merge(cfg2_o, wdata, wstrb);
          REG_CFG3: cfg3_o <= strb_merge(cfg3_o, wdata, wstrb);
          default: ;
        endcase
      end
      // A completion on the same edge as the clear must not be lost
      if (done_i) begin
        done_r <= 1'b1;
      end else if (done_w1c) begin
        done_r <= 1'b0;
      end
`ifdef HOG_AXIL_IRQ_EN
      if (we && (waddr == REG_IRQ_EN) && wstrb[0]) begin
        irq_en_r <= wdata[0];
      end
      irq_o <= done_r & irq_en_r;
`else
      irq_en_r <= 1'b0;
      irq_o    <= 1'b0;
`endif
    end
  end

  // Read mux; STATUS.ready is the live core signal
  always_comb begin
    rdata = 32'h0;
    case (raddr)
      REG_STATUS: begin
        rdata[STATUS_READY_BIT] = ready_i;
        rdata[STATUS_DONE_BIT]  = done_r;
      end
      REG_CFG0:    rdata = cfg0_o;
      REG_CFG1:    rdata = cfg1_o;
      REG_CFG2:    rdata = cfg2_o;
      REG_CFG3:    rdata = cfg3_o;
      REG_IRQ_EN:  rdata = {31'h0, irq_en_r};
      REG_VERSION: rdata = HOG_VERSION;
      default:     rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/hog_axil_slave.sv
// hog_axil_slave: AXI4-Lite GP slave for the HOG accelerator control bus.
// Holds the write/read handshake FSMs; registers live in hog_axil_reg_bank.
// Optional feature macro: HOG_AXIL_IRQ_EN.
module hog_axil_slave
  import hog_axil_pkg::*;
#(
  parameter int C_S_AXI_GP_DATA_WIDTH = 32,
  parameter int C_S_AXI_GP_ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                       s_axi_awprot,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [C_S_AXI_GP_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]                       s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                       s_axi_arprot,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [C_S_AXI_GP_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic                             start_o,
  output logic [31:0]                      cfg0_o,
  output logic [31:0]                      cfg1_o,
  output logic [31:0]                      cfg2_o,
  output logic [31:0]                      cfg3_o,
  input  logic                             ready_i,
  input  logic                             done_i,
  output logic                             irq_o
);

  wr_state_t   w_state;
  rd_state_t   r_state;
  logic        aw_held, w_held;
  logic [2:0]  aw_addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        aw_hs, w_hs, ar_hs, aw_have, w_have, commit;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] bank_rdata;
  logic        wr_err;
  logic        unused_ok;

  assign unused_ok   = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign s_axi_rresp = RESP_OKAY;

  // Handshake detection and selection of held vs. live write payload
  always_comb begin
    aw_hs   = s_axi_awvalid && s_axi_awready;
    w_hs    = s_axi_wvalid && s_axi_wready;
    ar_hs   = s_axi_arvalid && s_axi_arready;
    aw_have = aw_held || aw_hs;
    w_have  = w_held || w_hs;
    commit  = (w_state == W_IDLE) && aw_have && w_have;
    wr_addr = aw_held ? aw_addr_r : s_axi_awaddr[4:2];
    wr_data = w_held ? wdata_r : s_axi_wdata;
    wr_strb = w_held ? wstrb_r : s_axi_wstrb;
  end

  hog_axil_reg_bank u_reg_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .raddr   (s_axi_araddr[4:2]),
    .rdata   (bank_rdata),
    .wr_err  (wr_err),
    .ready_i (ready_i),
    .done_i  (done_i),
    .start_o (start_o),
    .cfg0_o  (cfg0_o),
    .cfg1_o  (cfg1_o),
    .cfg2_o  (cfg2_o),
    .cfg3_o  (cfg3_o),
    .irq_o   (irq_o)
  );

  // Write FSM: collect AW and W in any order, commit, then hold B until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_r     <= 3'd0;
      wdata_r       <= 32'h0;
      wstrb_r       <= 4'h0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state       <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_r <= s_axi_awaddr[4:2];
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_r <= s_axi_wdata;
              wstrb_r <= s_axi_wstrb;
            end
            s_axi_awready <= !aw_have;
            s_axi_wready  <= !w_have;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: register the read data on AR handshake, hold until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'h0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_rdata   <= bank_rdata;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hog_axil_slave.md
# hog_axil_slave

AXI4-Lite GP slave (responder) terminating the processor's control bus inside the HOG accelerator. Decodes eight 32-bit registers, converts register writes into start/config signals for the HOG core, and exposes core status for readback. It is the counterpart to the AXI4-Lite master the processor drives on the GP port.

## Interface
- C_S_AXI_GP_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_GP_ADDR_WIDTH, 5, byte address width (8 words)
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- s_axi_awaddr/awprot/awvalid  in  5/3/1; s_axi_awready  out  1
- s_axi_wdata/wstrb/wvalid  in  32/4/1; s_axi_wready  out  1
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1
- s_axi_araddr/arprot/arvalid  in  5/3/1; s_axi_arready  out  1
- s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1
- start_o  out  1  one-cycle start pulse to core
- cfg0_o..cfg3_o  out  32 each  image/BRAM config words
- ready_i  in  1  core idle; done_i  in  1  one-cycle completion pulse
- irq_o  out  1  level interrupt

## Operation
- Map (addr[4:2]; addr[1:0] ignored; awprot/arprot ignored):
  - 0x00 CTRL: write bit0=1 -> start_o pulse; reads 0
  - 0x04 STATUS: bit0 ready_i (live), bit1 DONE sticky; write 1 to bit1 clears
  - 0x08..0x14 CFG0..CFG3: RW, byte-enable per wstrb
  - 0x18 IRQ_EN: bit0 RW (see Configuration)
  - 0x1C VERSION: RO constant; write -> bresp SLVERR (2'b10), no effect
- All other responses OKAY (2'b00); rresp always OKAY.
- Write FSM W_IDLE/W_RESP. W_IDLE: awready = !aw_held, wready = !w_held; AW and W accepted independently in any order, latched. Edge where both are held/handshaking: register updated, bvalid=1, -> W_RESP. W_RESP: awready=wready=0; bvalid&&bready -> W_IDLE.
- Read FSM R_IDLE/R_DATA. R_IDLE: arready=1; on handshake rdata registered, rvalid=1, -> R_DATA, arready=0. rvalid&&rready -> R_IDLE.
- DONE set by done_i; done_i and W1C on same edge: set wins.
- irq_o = DONE & IRQ_EN, registered.
- Read and write to same register committing same edge: read returns pre-write value.

## Timing
- Reset values: awready, wready, arready, bvalid, rvalid, start_o, irq_o = 0; bresp, rresp, rdata = 0; CFG*, IRQ_EN, DONE = 0. arready/awready/wready rise the first edge after rst deasserts.
- Write: AW and W in same cycle (edge N) -> bvalid at N+1; CFG output changes at N+1.
- start_o high exactly one cycle, coincident with bvalid rising.
- Read: AR handshake at edge N -> rvalid at N+1. Max throughput one read per 2 cycles, one write per 2 cycles; channels independent.
- bvalid/rvalid and their payload held stable until ready; no new AW/W/AR accepted meanwhile.
- Async rst mid-transaction: all held addresses/data and pending responses dropped immediately, outputs to reset values.

## Configuration
- HOG_AXIL_IRQ_EN defined: IRQ_EN register implemented, irq_o as above.
- Undefined: 0x18 reads 0, writes return OKAY and are discarded, irq_o tied 0; DONE still readable.

## Structure
- hog_axil_pkg: register offsets, RESP_OKAY/RESP_SLVERR, VERSION constant, write/read state enums, DONE/READY bit indices.
- Sub-module hog_axil_reg_bank: decode, wstrb merge, storage, read mux; handshake FSMs stay in hog_axil_slave.

## Test plan
- Reset: assert rst mid-write with AW held -> all outputs 0, CFG0 unchanged, arready=1 one edge after release.
- Write CFG1=0xDEADBEEF, wstrb=4'b0101 over 0x0000_0000 -> read 0x0C returns 0x00AD00EF, rresp OKAY.
- W two cycles before AW to 0x08 data 0x12345678, bready low 3 cycles -> bvalid held 3 cycles, bresp 0, CFG0=0x12345678.
- Write 0x1 to CTRL -> start_o one cycle high; read 0x00 returns 0.
- done_i pulse with IRQ_EN=1 -> STATUS bit1=1, irq_o=1; W1C 0x2 -> both clear; W1C same cycle as done_i -> stays 1.
- Write 0x1C -> bresp 2'b10; read 0x1C returns VERSION unchanged.
